// File: rtl/enc_pkg.sv
// Shared types and helpers for the priority encoder family.
// Holds the encoder mode type and a multi-hot test used at capture.
package enc_pkg;

  typedef enum logic {
    ENC_FIXED = 1'b0,
    ENC_RR    = 1'b1
  } enc_mode_e;

  localparam int unsigned ENC_MAX_N = 256;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  function automatic logic multi_hot(input logic [ENC_MAX_N-1:0] v);
    logic [ENC_MAX_N-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return |(v & (v - one));
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority picker.
// Returns the highest (HIGH_FIRST=1) or lowest (HIGH_FIRST=0) set index of vec.
module prio_pick #(
  parameter  int unsigned N          = 8,
  parameter  bit          HIGH_FIRST = 1'b1,
  localparam int unsigned W          = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    if (HIGH_FIRST) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (vec[i]) begin
          found = 1'b1;
          idx   = W'(i);
        end
      end
    end else begin
      for (int unsigned i = N; i > 0; i--) begin
        if (vec[i-1]) begin
          found = 1'b1;
          idx   = W'(i - 1);
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// N:log2(N) priority encoder with fixed or round-robin resolution and a
// registered valid/ready output stage.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic [W-1:0] rr_ptr
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  enc_mode_e              mode_in;
  enc_mode_e              cap_mode;
  logic [N-1:0]           rr_mask;
  logic [N-1:0]           req_masked;
  logic [N-1:0]           win_onehot;
  logic [ENC_MAX_N-1:0]   req_ext;
  logic                   fix_found;
  logic                   msk_found;
  logic                   all_found;
  logic [W-1:0]           fix_idx;
  logic [W-1:0]           msk_idx;
  logic [W-1:0]           all_idx;
  logic [W-1:0]           win_idx;
  logic                   have_req;
  logic                   load;
  logic                   accept;
  logic [W-1:0]           ptr_next;

  prio_pick #(.N(N), .HIGH_FIRST(1'b1)) u_pick_fixed (
    .vec   (req),
    .found (fix_found),
    .idx   (fix_idx)
  );

  prio_pick #(.N(N), .HIGH_FIRST(1'b0)) u_pick_masked (
    .vec   (req_masked),
    .found (msk_found),
    .idx   (msk_idx)
  );

  prio_pick #(.N(N), .HIGH_FIRST(1'b0)) u_pick_all (
    .vec   (req),
    .found (all_found),
    .idx   (all_idx)
  );

  always_comb begin
    mode_in = enc_mode_e'(mode);
    for (int unsigned i = 0; i < N; i++) begin
      rr_mask[i] = (W'(i) >= rr_ptr);
    end
    req_masked = req & rr_mask;

    // Masked search covers [rr_ptr, N-1]; falling back to the full vector gives the wrap.
    if (mode_in == ENC_FIXED) begin
      win_idx  = fix_idx;
      have_req = fix_found;
    end else begin
      win_idx  = msk_found ? msk_idx : all_idx;
      have_req = all_found;
    end

    for (int unsigned i = 0; i < N; i++) begin
      win_onehot[i] = (W'(i) == win_idx);
    end

    req_ext        = '0;
    req_ext[N-1:0] = req;

    load     = !out_valid || out_ready;
    accept   = out_valid && out_ready;
    ptr_next = (out_idx == LAST) ? '0 : out_idx + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      rr_ptr     <= '0;
      cap_mode   <= ENC_FIXED;
    end else begin
      if (accept && (cap_mode == ENC_RR)) begin
        rr_ptr <= ptr_next;
      end
      if (load) begin
        if (have_req) begin
          out_valid  <= 1'b1;
          out_idx    <= win_idx;
          out_onehot <= win_onehot;
          out_multi  <= multi_hot(req_ext);
          cap_mode   <= mode_in;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised N:log2(N) encoder, successor to the 4:2 encoder. Adds priority resolution for multi-hot inputs, a runtime-selectable fixed-priority or round-robin mode, and a registered output stage with valid/ready back-pressure. It sits between a bank of request lines and a single downstream consumer of encoded indices, such as an arbiter grant path or an interrupt vector fetch.

## Interface
- N, default 8: number of request inputs; legal range 2..256, need not be a power of two.
- W (localparam), $clog2(N): index width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  N  request vector; any number of bits may be set.
- mode  in  1  ENC_FIXED (0) or ENC_RR (1); sampled only at capture.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_idx  out  W  encoded winning index.
- out_onehot  out  N  one-hot form of out_idx.
- out_multi  out  1  more than one req bit was set at capture.
- rr_ptr  out  W  current round-robin search start; for observation only.

## Operation
- Capture condition: `load = !out_valid || out_ready`. When load is 1 and |req is 1, the output registers capture the winner, out_valid is set to 1, and out_multi is set to (popcount(req) > 1).
- When load is 1 and req == 0, out_valid is cleared to 0 (bubble). out_idx, out_onehot and out_multi hold their old values and are don't-care.
- When load is 0 (valid && !ready), all outputs and rr_ptr hold. req is ignored and nothing is queued.
- ENC_FIXED: the highest set index wins. For a one-hot req this matches the plain encoder (req=4'b0100 gives idx 2).
- ENC_RR: the lowest set index at or above rr_ptr wins. If no such bit exists, the lowest set index overall wins (wrap).
- rr_ptr update: only on an accepted transfer (out_valid && out_ready) of a result captured in ENC_RR. It becomes (out_idx+1), wrapping from N-1 to 0, and is never set to a value ≥ N.
- Fixed-mode transfers leave rr_ptr unchanged. Switching modes needs no flush.
- Each captured result records its own mode bit internally, and that bit gates the rr_ptr update.

## Timing
- Latency is 1 cycle: req/mode sampled at edge t appear on the outputs after edge t.
- Throughput is 1 result per cycle while out_ready is held high.
- Simultaneous accept and capture: on the same edge, the old result retires, rr_ptr advances from the old out_idx, and the new winner is computed with the pre-edge rr_ptr. This means back-to-back round-robin captures under constant out_ready use a pointer one result stale.
- The bench models this exact behaviour. It does not require alternation on consecutive cycles; fairness is checked over accepted sequences with out_ready toggled.
- Reset (synchronous, rst_n=0 at an edge), including mid-transfer: out_valid=0, out_idx=0, out_onehot=0, out_multi=0, rr_ptr=0. The pending result is discarded and out_ready is ignored on that edge.
- out_onehot always equals 1<<out_idx whenever out_valid=1.

## Structure
- Package enc_pkg holds the mode typedef (enum logic: ENC_FIXED=1'b0, ENC_RR=1'b1) and a popcount-greater-than-one function.
- Sub-module prio_pick is purely combinational. Parameters: N, HIGH_FIRST. Ports: vec in, found out, idx out.
- The top instantiates prio_pick three times:
  - fixed mode: HIGH_FIRST=1, on req.
  - round-robin masked: HIGH_FIRST=0, on req & ~((1<<rr_ptr)-1).
  - round-robin unmasked: HIGH_FIRST=0, on req.
- Top-level RR select: use the masked result if its found=1, else the unmasked result.
- The top level owns only the output registers, rr_ptr and the captured-mode bit.

## Test plan
- One-hot sweep, N=4, ENC_FIXED, out_ready=1: req=0001/0010/0100/1000 → out_idx 0/1/2/3 one cycle later, out_multi=0, out_onehot echoes req.
- Fixed priority, N=8: req=8'b0101_0010 → out_idx=6, out_multi=1. Then req=0 → out_valid=0 on the next cycle.
- Back-pressure, N=4: capture req=0110 with out_ready=0 for 3 cycles while req changes to 0001. Outputs hold idx=2, rr_ptr holds. Raising out_ready retires it, and idx=0 appears the following cycle.
- Round-robin, N=4, req held at 1011, out_ready=1 on alternate cycles: accepted sequence is 0,1,3,0,1. rr_ptr reads 1,2,0,1,2 after each accept.
- Non-power-of-two N=5, ENC_RR: accept idx=4 → rr_ptr=0, never 5. Then req=10001 → idx 0.
- Reset mid-transfer: out_valid=1, out_ready=0, rr_ptr=3. Assert rst_n=0 for 1 edge → all outputs 0 and rr_ptr=0. The next capture with req=1000 in ENC_RR → idx 3.
